// File: rtl/svf_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the SVF coefficient sequencer.
package svf_pkg;

    localparam int unsigned FRAC_BITS  = 12;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned MIDI_W     = 7;
    localparam int unsigned DIV_CYCLES = 24;
    localparam int unsigned DVD_W      = 25;
    localparam int unsigned QUO_W      = 24;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ST_W       = 4;

    localparam logic [DATA_W-1:0] ONE      = 16'h1000;
    localparam logic [DVD_W-1:0]  DIVIDEND = 25'h100_0000;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOOKUP = 4'd1;
    localparam logic [3:0] ST_SUM    = 4'd2;
    localparam logic [3:0] ST_MUL1   = 4'd3;
    localparam logic [3:0] ST_ADDM   = 4'd4;
    localparam logic [3:0] ST_DIV    = 4'd5;
    localparam logic [3:0] ST_MUL2   = 4'd6;
    localparam logic [3:0] ST_MUL3   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // Clamp a wide unsigned result to 16 bits.
    function automatic logic [DATA_W-1:0] sat16(input logic [31:0] x);
        return (|x[31:DATA_W]) ? 16'hFFFF : x[DATA_W-1:0];
    endfunction

    // Q4.12 mantissas of 2^(f/9), f = 0..8.
    function automatic logic [DATA_W-1:0] g_mant(input logic [3:0] f);
        logic [DATA_W-1:0] m;
        case (f)
            4'd0:    m = 16'h1000;
            4'd1:    m = 16'h1148;
            4'd2:    m = 16'h12AA;
            4'd3:    m = 16'h1429;
            4'd4:    m = 16'h15C6;
            4'd5:    m = 16'h1784;
            4'd6:    m = 16'h1966;
            4'd7:    m = 16'h1B6F;
            default: m = 16'h1DA1;
        endcase
        return m;
    endfunction

    // g table contents: g = 1.0 * 2^((note-69)/9), saturated to 0xFFFF.
    function automatic logic [DATA_W-1:0] g_curve(input logic [MIDI_W-1:0] note);
        logic [7:0]  d;
        logic [3:0]  oct;
        logic [3:0]  f;
        logic [31:0] mant;
        logic [31:0] val;
        d    = 8'(note) + 8'd3;
        oct  = 4'(d / 8'd9);
        f    = 4'(d % 8'd9);
        mant = 32'(g_mant(f));
        if (oct >= 4'd8) val = mant << (oct - 4'd8);
        else             val = mant >> (4'd8 - oct);
        return sat16(val);
    endfunction

endpackage

// File: rtl/svf_coeff_sequencer_serial_divider.sv
// Restoring serial divider: 25-bit dividend / 16-bit divisor, one quotient bit per cycle.
// The quotient MSB is always 0 for divisor > 1, so its step is folded into the load and
// the remaining 24 bits take DIV_CYCLES cycles; done pulses DIV_CYCLES cycles after start.
module serial_divider
    import svf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DVD_W-1:0]  dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [QUO_W-1:0]  quotient,
    output logic              done
);

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W-1:0] cur_rem;
    logic [DATA_W-1:0] cur_dvsr;
    logic [DATA_W-1:0] next_rem;
    logic [QUO_W-1:0]  cur_dq;
    logic [QUO_W-1:0]  next_dq;
    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [CNT_W-1:0]  cnt;
    logic              running;

    // One restoring step; on start it operates on the freshly presented operands.
    always_comb begin
        cur_rem  = rem;
        cur_dq   = quotient;
        cur_dvsr = dvsr;
        if (start) begin
            cur_rem  = DATA_W'(dividend[DVD_W-1]);
            cur_dq   = dividend[QUO_W-1:0];
            cur_dvsr = divisor;
        end
        shifted  = {cur_rem, cur_dq[QUO_W-1]};
        ge       = (shifted >= {1'b0, cur_dvsr});
        next_rem = ge ? DATA_W'(shifted - {1'b0, cur_dvsr}) : DATA_W'(shifted);
        next_dq  = {cur_dq[QUO_W-2:0], ge};
    end

    // Iteration control; a new start restarts the division from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dvsr     <= '0;
            quotient <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= next_rem;
                quotient <= next_dq;
                dvsr     <= divisor;
                cnt      <= CNT_W'(DIV_CYCLES - 1);
                running  <= 1'b1;
            end else if (running) begin
                rem      <= next_rem;
                quotient <= next_dq;
                cnt      <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/svf_coeff_sequencer.sv
// Sequences g/k/a1/a2/a3 lowpass SVF coefficients per MIDI note with one shared multiplier
// and a serial divider; publishes a coherent set with coincident valid and flush pulses.
module svf_coeff_sequencer
    import svf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_note_valid,
    input  logic [MIDI_W-1:0] i_midi,
    input  logic [DATA_W-1:0] i_k,
    output logic [DATA_W-1:0] o_g,
    output logic [DATA_W-1:0] o_k,
    output logic [DATA_W-1:0] o_a1,
    output logic [DATA_W-1:0] o_a2,
    output logic [DATA_W-1:0] o_a3,
    output logic              o_coef_valid,
    output logic              o_flush,
    output logic              o_busy
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   next_state;
    logic [MIDI_W-1:0] midi_q;
    logic [DATA_W-1:0] k_q;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] p_q;
    logic [DATA_W-1:0] a1_q;
    logic [DATA_W-1:0] a2_q;
    logic [DATA_W-1:0] mul_b;
    logic [31:0]       prod;
    logic [DATA_W-1:0] mul_res;
    logic [DATA_W-1:0] m_val;
    logic              div_start;
    logic              div_done;
    logic [QUO_W-1:0]  quotient;
    logic              update;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next state; a strobe in any state restarts at LOOKUP (latest note wins).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   next_state = ST_IDLE;
            ST_LOOKUP: next_state = ST_SUM;
            ST_SUM:    next_state = ST_MUL1;
            ST_MUL1:   next_state = ST_ADDM;
            ST_ADDM:   next_state = ST_DIV;
            ST_DIV:    if (div_done) next_state = ST_MUL2;
            ST_MUL2:   next_state = ST_MUL3;
            ST_MUL3:   next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (i_note_valid) next_state = ST_LOOKUP;
    end

    // Shared multiplier: g times s, a1 or a2 depending on the stage.
    always_comb begin
        mul_b = s_q;
        case (state)
            ST_MUL2: mul_b = a1_q;
            ST_MUL3: mul_b = a2_q;
            default: mul_b = s_q;
        endcase
        prod      = 32'(g_q) * 32'(mul_b);
        mul_res   = sat16(prod >> FRAC_BITS);
        m_val     = sat16(32'(ONE) + 32'(p_q));
        div_start = (state == ST_ADDM) && (next_state == ST_DIV);
        update    = (state == ST_MUL3) && (next_state == ST_DONE);
    end

    serial_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (m_val),
        .quotient (quotient),
        .done     (div_done)
    );

    // Datapath registers and published outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            midi_q       <= '0;
            k_q          <= '0;
            g_q          <= '0;
            s_q          <= '0;
            p_q          <= '0;
            a1_q         <= '0;
            a2_q         <= '0;
            o_g          <= '0;
            o_k          <= '0;
            o_a1         <= '0;
            o_a2         <= '0;
            o_a3         <= '0;
            o_coef_valid <= 1'b0;
            o_flush      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            if (i_note_valid) begin
                midi_q <= i_midi;
                k_q    <= i_k;
            end
            case (state)
                ST_LOOKUP: g_q <= g_curve(midi_q);
                ST_SUM:    s_q <= sat16(32'(g_q) + 32'(k_q));
                ST_MUL1:   p_q <= mul_res;
                ST_DIV:    if (div_done) a1_q <= sat16(32'(quotient));
                ST_MUL2:   a2_q <= mul_res;
                default:   ;
            endcase
            o_coef_valid <= update;
            o_flush      <= update;
            o_busy       <= (next_state != ST_IDLE);
            if (update) begin
                o_g  <= g_q;
                o_k  <= k_q;
                o_a1 <= a1_q;
                o_a2 <= a2_q;
                o_a3 <= mul_res;
            end
        end
    end

endmodule
